// File: rtl/byte_serializer4.sv
// byte_serializer4: accepts 32-bit words on a valid/ready handshake and steps a
// 4:1 byte mux select so one byte per cycle leaves under downstream backpressure.
module byte_serializer4 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_len,
  output logic [7:0]  mux_a,
  output logic [7:0]  mux_b,
  output logic [7:0]  mux_c,
  output logic [7:0]  mux_d,
  output logic [1:0]  mux_sel,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  typedef struct packed {
    logic [3:0][7:0] bytes;
    logic [1:0]      len;
    logic            vld;
  } entry_t;

  entry_t     r_act;
  entry_t     r_pend;
  logic [1:0] r_idx;

  entry_t     w_act_nxt;
  entry_t     w_pend_nxt;
  entry_t     w_new;
  logic [1:0] w_idx_nxt;
  logic       w_accept;
  logic       w_xfer;
  logic       w_eow;

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_act.vld && out_ready;
  assign w_eow    = w_xfer && (r_idx == r_act.len);

  always_comb begin
    w_new.bytes = in_data;
    w_new.len   = in_len;
    w_new.vld   = 1'b1;
  end

  // Next-state: promote pending at end of word, otherwise fill the first free entry.
  always_comb begin
    w_act_nxt  = r_act;
    w_pend_nxt = r_pend;
    w_idx_nxt  = r_idx;
    if (w_eow) begin
      if (r_pend.vld) begin
        w_act_nxt      = r_pend;
        w_idx_nxt      = 2'd0;
        w_pend_nxt.vld = 1'b0;
        if (w_accept) begin
          w_pend_nxt = w_new;
        end
      end else if (w_accept) begin
        w_act_nxt = w_new;
        w_idx_nxt = 2'd0;
      end else begin
        // Bytes and len are kept so the mux inputs hold their last values.
        w_act_nxt.vld = 1'b0;
      end
    end else begin
      if (w_xfer) begin
        w_idx_nxt = r_idx + 2'd1;
      end
      if (w_accept) begin
        if (!r_act.vld) begin
          w_act_nxt = w_new;
          w_idx_nxt = 2'd0;
        end else begin
          w_pend_nxt = w_new;
        end
      end
    end
  end

  // NOTE: the byte registers are reset too, because the mux inputs must read 00
  // after reset; a synchronous reset keeps them ordinary enabled flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act  <= '0;
      r_pend <= '0;
      r_idx  <= 2'd0;
    end else begin
      r_act  <= w_act_nxt;
      r_pend <= w_pend_nxt;
      r_idx  <= w_idx_nxt;
    end
  end

  always_comb begin
    in_ready  = !r_pend.vld;
    out_valid = r_act.vld;
    out_last  = r_act.vld && (r_idx == r_act.len);
    mux_sel   = MSB_FIRST ? (r_act.len - r_idx) : r_idx;
    mux_a     = r_act.bytes[0];
    mux_b     = r_act.bytes[1];
    mux_c     = r_act.bytes[2];
    mux_d     = r_act.bytes[3];
    busy      = r_act.vld || r_pend.vld;
  end

endmodule

// File: tb/tb_byte_serializer4.sv
// Bench for byte_serializer4: an LSB-first and an MSB-first instance share stimulus;
// each has its own expected-byte queue drained by a monitor on the falling edge.
module tb_byte_serializer4;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [1:0] sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_len = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  mux_a, mux_b, mux_c, mux_d;
  logic [1:0]  mux_sel;
  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_mux_a, m_mux_b, m_mux_c, m_mux_d;
  logic [1:0]  m_mux_sel;

  exp_t q_lsb[$];
  exp_t q_msb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  byte_serializer4 #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .mux_a(mux_a), .mux_b(mux_b),
    .mux_c(mux_c), .mux_d(mux_d), .mux_sel(mux_sel), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  byte_serializer4 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_len(in_len), .mux_a(m_mux_a), .mux_b(m_mux_b),
    .mux_c(m_mux_c), .mux_d(m_mux_d), .mux_sel(m_mux_sel), .out_valid(m_out_valid),
    .out_last(m_out_last), .out_ready(out_ready), .busy(m_busy)
  );

  // Downstream 4:1 byte mux fed by the serializer.
  function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  logic [7:0] w_out, w_m_out;
  assign w_out   = pick(mux_sel, mux_a, mux_b, mux_c, mux_d);
  assign w_m_out = pick(m_mux_sel, m_mux_a, m_mux_b, m_mux_c, m_mux_d);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] data, input logic [1:0] len);
    exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.b = data[8*i +: 8];
      e.last = (i == int'(len));
      e.sel = 2'(i);
      q_lsb.push_back(e);
      e.b = data[8*(int'(len) - i) +: 8];
      e.sel = 2'(int'(len) - i);
      q_msb.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge with in_valid low.
  task automatic send(input logic [31:0] data, input logic [1:0] len);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_word(data, len);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_busy || q_lsb.size() != 0 || q_msb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", {30'b0, busy, m_busy}, 32'd0);
    check("idle_queues_empty", q_lsb.size() + q_msb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop and compare on every accepted output byte.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q_lsb.size() == 0) begin
        check("lsb_unexpected_byte_qsize", 32'd0, 32'd1);
      end else begin
        e = q_lsb.pop_front();
        check("lsb_byte", {24'b0, w_out}, {24'b0, e.b});
        check("lsb_last", {31'b0, out_last}, {31'b0, e.last});
        check("lsb_sel", {30'b0, mux_sel}, {30'b0, e.sel});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_out_valid && out_ready) begin
      if (q_msb.size() == 0) begin
        check("msb_unexpected_byte_qsize", 32'd0, 32'd1);
      end else begin
        e = q_msb.pop_front();
        check("msb_byte", {24'b0, w_m_out}, {24'b0, e.b});
        check("msb_last", {31'b0, m_out_last}, {31'b0, e.last});
        check("msb_sel", {30'b0, m_mux_sel}, {30'b0, e.sel});
      end
    end
  end

  logic [7:0] exp_single [4];
  logic [7:0] exp_b2b    [5];
  logic [7:0] exp_msb    [3];

  initial begin
    exp_single = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_b2b    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0};
    exp_msb    = '{8'h99, 8'h88, 8'h77};

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mux_sel", {30'b0, mux_sel}, 32'd0);
    check("rst_mux_abcd", {mux_a, mux_b, mux_c, mux_d}, 32'h0);
    @(posedge clk);
    #1;

    // Single word, LSB-first: four consecutive bytes starting one cycle after accept
    send(32'hDDCCBBAA, 2'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("single_valid", {31'b0, out_valid}, 32'd1);
      check("single_byte", {24'b0, w_out}, {24'b0, exp_single[k]});
      check("single_last", {31'b0, out_last}, {31'b0, k == 3});
    end
    @(negedge clk);
    check("single_busy_after", {31'b0, busy}, 32'd0);
    check("single_valid_after", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back words with no bubble
    send(32'h04030201, 2'd3);
    fork
      send(32'h000000F0, 2'd0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("b2b_valid", {31'b0, out_valid}, 32'd1);
          check("b2b_byte", {24'b0, w_out}, {24'b0, exp_b2b[k]});
          check("b2b_last", {31'b0, out_last}, {31'b0, (k == 3) || (k == 4)});
        end
      end
    join
    wait_idle();

    // Backpressure: stall three cycles on the second byte while pending fills
    send(32'h44332211, 2'd3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        send(32'h00006655, 2'd1);
        in_data  = 32'hCAFE0077;
        in_len   = 2'd0;
        in_valid = 1'b1;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_valid", {31'b0, out_valid}, 32'd1);
          check("bp_sel", {30'b0, mux_sel}, 32'd1);
          check("bp_byte", {24'b0, w_out}, 32'h22);
          check("bp_last", {31'b0, out_last}, 32'd0);
        end
      end
    join
    check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'hCAFE0077, 2'd0);
    wait_idle();

    // MSB-first instance: select 2,1,0 over a three-byte word
    send(32'hEE998877, 2'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("msb_dir_sel", {30'b0, m_mux_sel}, 32'(2 - k));
      check("msb_dir_byte", {24'b0, w_m_out}, {24'b0, exp_msb[k]});
      check("msb_dir_last", {31'b0, m_out_last}, {31'b0, k == 2});
    end
    wait_idle();

    // Reset mid-word with pending full
    send(32'h0D0C0B0A, 2'd3);
    send(32'h1D1C1B1A, 2'd3);
    #0 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_lsb.delete();
    q_msb.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_busy", {30'b0, busy, m_busy}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_mux_abcd", {mux_a, mux_b, mux_c, mux_d}, 32'h0);
    @(posedge clk);
    #1;
    send(32'h87654321, 2'd3);
    @(negedge clk);
    check("post_rst_sel", {30'b0, mux_sel}, 32'd0);
    check("post_rst_byte", {24'b0, w_out}, 32'h21);
    @(posedge clk);
    #1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
